// File: rtl/change_dispenser_pkg.sv
// Shared vending-machine definitions: coin values, coin codes and the
// change-dispenser state encoding, used by both the acceptor and dispenser sides.
package vend_pkg;

  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;
  localparam int DOLLAR_C  = 100;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_REQ  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } disp_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending FSM / coin ejector (master) and the change
// dispenser (slave), including the dispenser's state for observation.
interface change_dispenser_if #(
  parameter int AMT_W = 32,
  parameter int CNT_W = 8
);
  import vend_pkg::*;

  logic             start;
  logic [AMT_W-1:0] amount;
  logic             abort;
  logic             coin_ack;
  logic             dollar_out;
  logic             quarter_out;
  logic             dime_out;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] short;
  logic [CNT_W-1:0] n_dollar;
  logic [CNT_W-1:0] n_quarter;
  logic [CNT_W-1:0] n_dime;
  disp_state_t      state;

  // Coin handshake: a request line (dollar_out/quarter_out/dime_out) acts as
  // valid and coin_ack as ready; a coin transfers on a rising edge where both
  // are high, and the request stays high and unchanged until that edge.
  modport master (
    output start, amount, abort, coin_ack,
    input  dollar_out, quarter_out, dime_out, busy, done, short,
           n_dollar, n_quarter, n_dime, state
  );

  modport slave (
    input  start, amount, abort, coin_ack,
    output dollar_out, quarter_out, dime_out, busy, done, short,
           n_dollar, n_quarter, n_dime, state
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Maps a remaining change amount to the next coin to pay out; purely
// combinational so display logic can reuse it.
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 32
) (
  input  logic [AMT_W-1:0] i_rem,
  output coin_t            o_coin
);

  logic w_ends_in_5;

  // A quarter first turns an odd-five amount into a dime-payable one.
  assign w_ends_in_5 = ((i_rem % AMT_W'(10)) == AMT_W'(5));

  always_comb begin
    o_coin = COIN_NONE;
    if (w_ends_in_5 && (i_rem >= AMT_W'(QUARTER_C))) begin
      o_coin = COIN_QUARTER;
    end else if (i_rem >= AMT_W'(DOLLAR_C)) begin
      o_coin = COIN_DOLLAR;
    end else if (i_rem >= AMT_W'(DIME_C)) begin
      o_coin = COIN_DIME;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: splits an amount into dollar/quarter/dime coins and
// requests them one at a time from the ejector, reporting counts and residue.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 32,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  disp_state_t      r_state, w_state;
  logic [AMT_W-1:0] r_rem, w_rem, r_short, w_short;
  logic [CNT_W-1:0] r_n_dol, w_n_dol, r_n_qtr, w_n_qtr, r_n_dime, w_n_dime;
  logic             r_dol, w_dol, r_qtr, w_qtr, r_dime, w_dime;
  logic             r_busy, w_busy, r_done, w_done;
  logic [GW-1:0]    r_gap, w_gap;
  coin_t            w_sel;
  logic [AMT_W-1:0] w_paid;

  coin_select #(.AMT_W(AMT_W)) u_coin_select (
    .i_rem  (r_rem),
    .o_coin (w_sel)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign w_paid = r_dol ? AMT_W'(DOLLAR_C) :
                  r_qtr ? AMT_W'(QUARTER_C) : AMT_W'(DIME_C);

  always_comb begin
    w_state  = r_state;
    w_rem    = r_rem;
    w_short  = r_short;
    w_n_dol  = r_n_dol;
    w_n_qtr  = r_n_qtr;
    w_n_dime = r_n_dime;
    w_dol    = r_dol;
    w_qtr    = r_qtr;
    w_dime   = r_dime;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_gap    = r_gap;
    case (r_state)
      ST_IDLE: begin
        // The done pulse is shown from IDLE, so busy drops one edge later.
        if (r_done) begin
          w_busy = 1'b0;
        end else if (bus.start && !r_busy) begin
          w_rem    = bus.amount;
          w_short  = '0;
          w_n_dol  = '0;
          w_n_qtr  = '0;
          w_n_dime = '0;
          w_busy   = 1'b1;
          w_state  = ST_SEL;
        end
      end
      ST_SEL: begin
        if (bus.abort || (w_sel == COIN_NONE)) begin
          w_state = ST_DONE;
        end else begin
          w_dol   = (w_sel == COIN_DOLLAR);
          w_qtr   = (w_sel == COIN_QUARTER);
          w_dime  = (w_sel == COIN_DIME);
          w_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.coin_ack) begin
          w_rem = r_rem - w_paid;
          if (r_dol)  w_n_dol  = sat_inc(r_n_dol);
          if (r_qtr)  w_n_qtr  = sat_inc(r_n_qtr);
          if (r_dime) w_n_dime = sat_inc(r_n_dime);
          w_dol  = 1'b0;
          w_qtr  = 1'b0;
          w_dime = 1'b0;
          w_gap  = '0;
          if (bus.abort)       w_state = ST_DONE;
          else if (GAP_CYC == 0) w_state = ST_SEL;
          else                 w_state = ST_GAP;
        end else if (bus.abort) begin
          w_dol   = 1'b0;
          w_qtr   = 1'b0;
          w_dime  = 1'b0;
          w_state = ST_DONE;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          w_state = ST_DONE;
        end else if (r_gap == GW'(GAP_CYC - 1)) begin
          w_state = ST_SEL;
        end else begin
          w_gap = r_gap + 1'b1;
        end
      end
      ST_DONE: begin
        w_done  = 1'b1;
        w_short = r_rem;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_short  <= '0;
      r_n_dol  <= '0;
      r_n_qtr  <= '0;
      r_n_dime <= '0;
      r_dol    <= 1'b0;
      r_qtr    <= 1'b0;
      r_dime   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state;
      r_rem    <= w_rem;
      r_short  <= w_short;
      r_n_dol  <= w_n_dol;
      r_n_qtr  <= w_n_qtr;
      r_n_dime <= w_n_dime;
      r_dol    <= w_dol;
      r_qtr    <= w_qtr;
      r_dime   <= w_dime;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_gap    <= w_gap;
    end
  end

  assign bus.dollar_out  = r_dol;
  assign bus.quarter_out = r_qtr;
  assign bus.dime_out    = r_dime;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.short       = r_short;
  assign bus.n_dollar    = r_n_dol;
  assign bus.n_quarter   = r_n_qtr;
  assign bus.n_dime      = r_n_dime;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table, hand-written corner sequences and
// randomized payouts checked against an arithmetic coin-rule model.
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int AMT_W   = 32;
  localparam int CNT_W   = 8;
  localparam int GAP_CYC = 2;
  localparam int BUDGET  = 6000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) vif ();

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int amt;
    int ack_dly;
    int ab_coin;
    bit ab_ack;
    bit poke;
    int e_d;
    int e_q;
    int e_m;
    int e_short;
    int e_first;
    int e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference: pay coins by the selection rule on a plain integer, stopping at
  // the aborted coin (which counts only when acked in the same cycle).
  function automatic void model(input int amt, input int ab_coin, input bit ab_ack,
                                output int d, output int q, output int m, output int sh);
    int r;
    int c;
    r = amt; d = 0; q = 0; m = 0;
    for (int idx = 0; idx < 100000; idx++) begin
      if ((r % 10 == 5) && r >= 25) c = 25;
      else if (r >= 100)            c = 100;
      else if (r >= 10)             c = 10;
      else                          c = 0;
      if (c == 0) break;
      if (idx == ab_coin && !ab_ack) break;
      r -= c;
      if (c == 100) d++; else if (c == 25) q++; else m++;
      if (idx == ab_coin) break;
    end
    sh = r; d = sat(d); q = sat(q); m = sat(m);
  endfunction

  // driver: run one payout, acting as the ejector, and watch the handshake
  task automatic run_txn(input int amt, input int ack_dly, input int ab_coin,
                         input bit ab_ack, input bit poke,
                         output int o_d, output int o_q, output int o_m, output int o_sh,
                         output int t_d, output int t_q, output int t_m,
                         output int first_idx, output int done_idx);
    int held, low, coin_n;
    bit acked_last, seen_req, fin;
    logic [2:0] cur, prev_code;
    held = 0; low = 0; coin_n = 0; acked_last = 0; seen_req = 0; fin = 0;
    prev_code = '0; t_d = 0; t_q = 0; t_m = 0; first_idx = -1; done_idx = -1;
    o_d = 0; o_q = 0; o_m = 0; o_sh = 0;
    @(negedge clk);
    vif.start = 1'b1; vif.amount = amt;
    @(negedge clk);
    vif.start = 1'b0;
    chk("busy_after_start", vif.busy, 1);
    for (int idx = 0; idx < BUDGET && !fin; idx++) begin
      vif.coin_ack = 1'b0; vif.abort = 1'b0; vif.start = 1'b0;
      cur = {vif.dollar_out, vif.quarter_out, vif.dime_out};
      if ($countones(cur) > 1) chk("req_onehot", $countones(cur), 1);
      if (acked_last && cur != 3'b000) chk("req_drop_after_ack", cur, 0);
      acked_last = 0;
      if (vif.done) begin
        done_idx = idx;
        chk("req_low_during_done", cur, 0);
        o_d = vif.n_dollar; o_q = vif.n_quarter; o_m = vif.n_dime; o_sh = vif.short;
        fin = 1;
      end else if (cur != 3'b000) begin
        if (!seen_req) first_idx = idx;
        if (held == 0 && seen_req) chk("gap_low_cycles", low, GAP_CYC + 1);
        if (held > 0 && cur != prev_code) chk("req_stable", cur, prev_code);
        seen_req = 1;
        held++;
        prev_code = cur;
        if (held == ack_dly + 1) begin
          if (coin_n == ab_coin) begin
            vif.abort = 1'b1;
            vif.coin_ack = ab_ack;
          end else begin
            vif.coin_ack = 1'b1;
          end
          if (vif.coin_ack) begin
            if (cur[2]) t_d++;
            if (cur[1]) t_q++;
            if (cur[0]) t_m++;
          end
          coin_n++; held = 0; low = 0; acked_last = 1;
        end
      end else begin
        low++;
      end
      if (poke && idx == 3) begin
        vif.start = 1'b1; vif.amount = 5;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_single_pulse", vif.done, 0);
    chk("busy_low_after_done", vif.busy, 0);
    chk("short_held", vif.short, o_sh);
    t_d = sat(t_d); t_q = sat(t_q); t_m = sat(t_m);
  endtask

  initial begin
    int d, q, m, sh, td, tq, tm, fi, di;
    int ed, eq, em, es;
    int amt, dly, ab;
    bit aba;
    checks = 0; errors = 0;
    vif.start = 1'b0; vif.amount = '0; vif.abort = 1'b0; vif.coin_ack = 1'b0;
    rst = 1'b1;

    vecs.push_back('{130,   1, -1, 0, 0,   1, 0, 3,  0,  1, -1});
    vecs.push_back('{105,   1, -1, 0, 0,   0, 1, 8,  0,  1, -1});
    vecs.push_back('{5,     1, -1, 0, 0,   0, 0, 0,  5, -1,  2});
    vecs.push_back('{0,     0, -1, 0, 0,   0, 0, 0,  0, -1,  2});
    vecs.push_back('{250,   5, -1, 0, 0,   2, 0, 5,  0,  1, -1});
    vecs.push_back('{200,   2,  1, 0, 0,   1, 0, 0, 100, 1, -1});
    vecs.push_back('{200,   2,  1, 1, 0,   2, 0, 0,  0,  1, -1});
    vecs.push_back('{130,   0, -1, 0, 1,   1, 0, 3,  0,  1, -1});
    vecs.push_back('{15,    0, -1, 0, 0,   0, 0, 1,  5,  1, -1});
    vecs.push_back('{17,    0, -1, 0, 0,   0, 0, 1,  7,  1, -1});
    vecs.push_back('{35,    1, -1, 0, 0,   0, 1, 1,  0,  1, -1});
    vecs.push_back('{26000, 0, -1, 0, 0, 255, 0, 0,  0,  1, -1});

    repeat (3) @(negedge clk);
    chk("rst_busy", vif.busy, 0);
    chk("rst_done", vif.done, 0);
    chk("rst_reqs", {vif.dollar_out, vif.quarter_out, vif.dime_out}, 0);
    chk("rst_short", vif.short, 0);
    chk("rst_counts", {vif.n_dollar, vif.n_quarter, vif.n_dime}, 0);
    chk("rst_state", vif.state, ST_IDLE);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].amt, vecs[i].ack_dly, vecs[i].ab_coin, vecs[i].ab_ack, vecs[i].poke,
              d, q, m, sh, td, tq, tm, fi, di);
      chk($sformatf("vec%0d_n_dollar", i), d, vecs[i].e_d);
      chk($sformatf("vec%0d_n_quarter", i), q, vecs[i].e_q);
      chk($sformatf("vec%0d_n_dime", i), m, vecs[i].e_m);
      chk($sformatf("vec%0d_short", i), sh, vecs[i].e_short);
      chk($sformatf("vec%0d_seen_coins", i), {td[7:0], tq[7:0], tm[7:0]},
          {vecs[i].e_d[7:0], vecs[i].e_q[7:0], vecs[i].e_m[7:0]});
      if (vecs[i].e_first >= 0) chk($sformatf("vec%0d_first_req", i), fi, vecs[i].e_first);
      if (vecs[i].e_done >= 0)  chk($sformatf("vec%0d_done_cycle", i), di, vecs[i].e_done);
    end

    // reset in the middle of a coin request
    @(negedge clk);
    vif.start = 1'b1; vif.amount = 200;
    @(negedge clk);
    vif.start = 1'b0;
    for (int i = 0; i < 20 && !vif.dollar_out; i++) @(negedge clk);
    chk("midrst_req_seen", vif.dollar_out, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_reqs", {vif.dollar_out, vif.quarter_out, vif.dime_out}, 0);
    chk("midrst_busy", vif.busy, 0);
    chk("midrst_counts_short", {vif.n_dollar, vif.n_quarter, vif.n_dime, vif.short}, 0);
    di = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vif.done || vif.busy) di++;
    end
    chk("midrst_no_done", di, 0);
    run_txn(20, 1, -1, 0, 0, d, q, m, sh, td, tq, tm, fi, di);
    chk("after_rst_counts", {d[7:0], q[7:0], m[7:0]}, {8'd0, 8'd0, 8'd2});
    chk("after_rst_short", sh, 0);

    // randomized payouts against the model
    for (int n = 0; n < 40; n++) begin
      amt = $urandom_range(0, 600);
      dly = $urandom_range(0, 3);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      aba = 1'($urandom_range(0, 1));
      model(amt, ab, aba, ed, eq, em, es);
      run_txn(amt, dly, ab, aba, 0, d, q, m, sh, td, tq, tm, fi, di);
      chk($sformatf("rnd%0d_amt%0d_counts", n, amt), {d[7:0], q[7:0], m[7:0]},
          {ed[7:0], eq[7:0], em[7:0]});
      chk($sformatf("rnd%0d_amt%0d_short", n, amt), sh, es);
      chk($sformatf("rnd%0d_seen_coins", n), {td[7:0], tq[7:0], tm[7:0]},
          {ed[7:0], eq[7:0], em[7:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return controller on the output side of the vending machine. It accepts a change amount in cents from the vending FSM and pays it out as dollar, quarter and dime coins. Each coin is driven one at a time to the coin-ejector mechanism through a request/acknowledge handshake. It sits between the vending FSM's `change` result and the physical ejector, and reports per-coin counts plus any undispensable residue for the seven-segment change display.

## Interface
- `AMT_W`, 32, width of amount, remainder and residue in cents
- `CNT_W`, 8, width of each per-coin counter; counters saturate at all-ones
- `GAP_CYC`, 2, idle cycles between ack of one coin and request of the next (0 allowed)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request payout of `amount`; sampled only when `busy`=0
- `amount`  in  AMT_W  change in cents, latched on accepted `start`
- `abort`  in  1  stop payout; remaining value is reported as residue
- `coin_ack`  in  1  ejector has released the requested coin
- `dollar_out`, `quarter_out`, `dime_out`  out  1 each  coin request, at most one high, held until acked
- `busy`  out  1  high from accepted `start` until the end of the `done` cycle
- `done`  out  1  one-cycle pulse at payout end
- `short`  out  AMT_W  cents not paid; valid while `done`=1 and held until the next accepted `start`
- `n_dollar`, `n_quarter`, `n_dime`  out  CNT_W each  coins paid this transaction

## Operation
- States: IDLE, SEL, REQ, GAP, DONE. Reset puts the block in IDLE and sets every output to 0.
- IDLE: on `start`, latch `rem`←`amount`, clear the counters and `short`, set `busy`, and go to SEL. `start` while busy is ignored.
- SEL: coin choice, evaluated in this priority:
  - quarter if `rem`%10==5 and `rem`≥25;
  - else dollar if `rem`≥100;
  - else dime if `rem`≥10;
  - else none.
- SEL outcome: if a coin is chosen, register its request line and go to REQ. If none is chosen, go to DONE.
- The coin rule pays any multiple of 5 except 5 and 15. Those, and any non-multiple of 5, leave residue in `rem`.
- REQ: hold the request line until `coin_ack`=1. On ack:
  - `rem` −= coin value;
  - increment the matching counter, saturating;
  - drop the request;
  - go to GAP, or to SEL when `GAP_CYC`=0.
- GAP: count `GAP_CYC` cycles with all request lines low, then go to SEL.
- DONE: pulse `done`, set `short`←`rem`, and go to IDLE. `busy` falls on the following edge.
- `abort` in SEL, REQ or GAP: drop the request and go to DONE. The coin being requested is not counted, and `short` = current `rem`.
- `abort` and `coin_ack` in the same REQ cycle: the ack wins. The coin is counted and subtracted, then the block goes to DONE.
- `abort` in IDLE or DONE: no effect.
- `coin_ack` outside REQ: ignored.
- `rst` mid-payout: immediate return to IDLE with outputs zeroed. No `done` pulse is issued.

## Timing
- Accepted `start` at edge k: `busy`=1 after edge k, and the first coin request is high after edge k+1.
- `coin_ack` sampled high at edge m: the request is low after edge m, and the next request is high after edge m+`GAP_CYC`+1.
- Zero amount: `done` is high after edge k+2 with all counters 0 and `short`=0.
- Counters and `rem` update at the same edge as the ack.
- `short` changes only in DONE and on an accepted `start`.
- Request lines are registered (glitch-free). They never go high in the same cycle as `done`.

## Structure
- Shared package `vend_pkg` holds:
  - coin value constants `DIME_C`=10, `QUARTER_C`=25, `DOLLAR_C`=100;
  - the coin encoding (NONE, DIME, QUARTER, DOLLAR), shared with the coin-acceptor side;
  - the dispenser state encoding.
- Sub-module `coin_select`: purely combinational. It maps `rem` to a coin code using the SEL priority above and is reusable by the display logic.
- Top-level `change_dispenser` contains the FSM, `rem`, the gap counter and the saturating counters.

## Test plan
- `amount`=130, ack 1 cycle after each request → dollar, then 3 dimes. Counts 1/0/3, `short`=0.
- `amount`=105 → quarter, then 8 dimes. `amount`=5 → no coins, `short`=5, `done` at k+2.
- `amount`=250, ack delayed 5 cycles each time → request held steady 5 cycles per coin. Counts 2/0/5 dollar/quarter/dime, `short`=0, `GAP_CYC` low cycles observed between coins.
- `amount`=200, `abort` during the second dollar request with no ack → counts 1/0/0, `short`=100, one `done` pulse. Repeat with `abort` and `coin_ack` in the same cycle → counts 2/0/0, `short`=0.
- `start` pulsed while busy is ignored. `rst` asserted mid-REQ → all outputs 0 next cycle and no `done`. A fresh `start` of 20 afterwards → 2 dimes.
